add_arbiter: RTL and testbench
==============================

Name: add_arbiter

Overview:
Shares a single `adder` instance among NREQ requesters, such as PC increment, branch target and ALU add. Requests are granted by round-robin arbitration under valid/ready handshakes. The granted operands pass through the combinational adder and land in a one-entry registered response stage tagged with the requester index. The block sits between the fetch/execute control logic and the shared adder datapath.

Parameters:
- WIDTH, 32, operand and sum width in bits; passed to the internal adder.
- NREQ, 3, number of requesters (2..8).
- IDW, 2, width of the requester index; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  packed operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot grant; the request is accepted on a cycle where valid and ready are both high.
- rsp_valid  output  1  response register holds an unconsumed result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_sum  output  WIDTH  registered sum.
- rsp_cout  output  1  registered carry out.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, round-robin pointer ptr=0.
- req_ready is forced to all-zero while rst=1.
- can_accept = !rsp_valid || rsp_ready (combinational).
- Grant rule (combinational):
  - Scan indices ptr, ptr+1, ..., wrapping mod NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1, but only if can_accept.
  - Otherwise req_ready is all-zero.
  - At most one req_ready bit is high per cycle.
- Datapath: mux the operands of the granted index (index 0 when there is no grant) into the adder a/b inputs. The adder produces {cout,sum} = a+b, WIDTH+1 bits, with no modulus beyond that width.
- On a rising edge with a grant g:
  - rsp_sum <= sum, rsp_cout <= cout, rsp_id <= g, rsp_valid <= 1.
  - ptr <= (g+1) mod NREQ.
- On a rising edge with no grant and rsp_valid && rsp_ready: rsp_valid <= 0. rsp_sum, rsp_cout and rsp_id hold their values.
- On a rising edge with no grant and no drain: all state holds. ptr changes only on a grant.
- Latency and throughput:
  - Accept-to-response latency is exactly 1 cycle.
  - Throughput is 1 result per cycle while rsp_ready=1.
  - A drain and a new grant in the same cycle are legal. rsp_valid stays 1 and carries the new data.
- Backpressure: while rsp_valid=1 and rsp_ready=0, no grants occur. All response outputs stay stable.
- Requester contract: hold req_valid and operands stable until accepted. If a requester drops valid before acceptance, the arbiter regrants based on the current req_valid. Nothing is latched from an unaccepted request.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,NREQ-1,0,... A waiting requester sees at most NREQ-1 other grants before its own.
- Reset mid-operation: a pending response is discarded (rsp_valid=0 next edge) and ptr returns to 0. Requests presented during reset are not accepted.
- Index range: indices >= NREQ are never granted or emitted on rsp_id.

Test Plan:
1. Reset with all three req_valid=1: hold rst=1 for 2 cycles -> req_ready=000 throughout, rsp_valid=0, rsp_sum=0. The first cycle after reset grants index 0.
2. Single request, carry out: req_valid=010, req_a[1]=FFFFFFFF, req_b[1]=00000001, rsp_ready=1 -> req_ready=010 that cycle. Next cycle rsp_valid=1, rsp_id=1, rsp_sum=00000000, rsp_cout=1.
3. Round-robin under full load: req_valid=111, rsp_ready=1, operands a=i, b=10 for requester i -> grants 0,1,2,0 on consecutive cycles. Responses follow one cycle later with id 0,1,2,0 and sums 0A,0B,0C,0A.
4. Backpressure: after a grant, set rsp_ready=0 for 3 cycles with req_valid=111 -> req_ready=000 and rsp_id/sum/cout frozen. When rsp_ready=1 is restored, the next requester is granted the same cycle and the new response appears on the following edge.
5. Pointer skip: after a grant to index 2, present req_valid=101 -> index 0 is granted, then index 2. Requester 1 being idle causes no stall.
6. Reset mid-operation: while rsp_valid=1 and rsp_ready=0, pulse rst for 1 cycle -> rsp_valid=0 on that edge, and ptr=0 so the next grant with req_valid=111 goes to index 0.
7. Boundary: 80000000+80000000 -> sum=00000000, cout=1. 7FFFFFFF+00000001 -> sum=80000000, cout=0. FFFFFFFF+FFFFFFFF -> sum=FFFFFFFE, cout=1.

Source files
------------

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with a
// one-entry registered response stage tagged by requester index.

module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned SW = WIDTH + 1;

  assign {cout, sum} = SW'(a) + SW'(b);
endmodule

module add_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;

  logic             can_accept;
  logic [NREQ-1:0]  grant;
  logic             grant_any;
  logic             found;
  logic [IDW-1:0]   gnt_id;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cout;

  assign can_accept = !rsp_valid_q || rsp_ready;

  // Two-pass priority scan: indices at/after ptr first, then the wrap-around.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    if (!rst && can_accept) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && IDW'(i) >= ptr_q && req_valid[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gnt_id   = IDW'(i);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!found && IDW'(i) < ptr_q && req_valid[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gnt_id   = IDW'(i);
        end
      end
    end
  end

  assign grant_any = |grant;
  assign req_ready = grant;

  // Operand mux; falls back to requester 0 when nothing is granted.
  always_comb begin
    add_a = req_a[WIDTH-1:0];
    add_b = req_b[WIDTH-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        add_a = req_a[i*WIDTH +: WIDTH];
        add_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    if (grant_any) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_sum_d   = add_sum;
      rsp_cout_d  = add_cout;
      ptr_d       = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: a reference arbiter model pushes expected
// responses at grant time; they are popped and compared one edge later.

module tb_add_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREQ  = 3;
  localparam int unsigned IDW   = 2;
  localparam int unsigned RW    = 1 + IDW + 1 + WIDTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [RW-1:0]         rsp_obs;

  int errors = 0;
  int checks = 0;

  int            m_ptr = 0;
  bit            m_rv  = 1'b0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] cur = '0;

  add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  always #5 clk = ~clk;

  assign rsp_obs = {rsp_valid, rsp_id, rsp_cout, rsp_sum};

  // Reference grant: scan from the model pointer, only when the stage can take data.
  function automatic logic [NREQ-1:0] calc_gnt();
    logic [NREQ-1:0] g;
    int idx;
    g = '0;
    if (rst || (m_rv && !rsp_ready)) return g;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Advance the model for this cycle, then clock the DUT.
  task automatic tick();
    logic [NREQ-1:0] g;
    logic [WIDTH:0]  s;
    int              id;
    g  = calc_gnt();
    id = 0;
    if (rst) begin
      m_ptr = 0;
      m_rv  = 1'b0;
      exp_q.delete();
      cur   = '0;
    end else if (g != '0) begin
      for (int k = 0; k < NREQ; k++) if (g[k]) id = k;
      s = {1'b0, req_a[id*WIDTH +: WIDTH]} + {1'b0, req_b[id*WIDTH +: WIDTH]};
      exp_q.push_back({1'b1, IDW'(id), s[WIDTH], s[WIDTH-1:0]});
      m_ptr = (id + 1) % NREQ;
      m_rv  = 1'b1;
    end else if (m_rv && rsp_ready) begin
      m_rv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic next_exp();
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = 'x;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i + 1), WIDTH'(5));
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 3'b000) begin
        errors++;
        $display("FAIL reset_ready cyc%0d: got %b expected 000", c, req_ready);
      end
      tick();
    end
    checks++;
    if (rsp_obs !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got %h expected %h", rsp_obs, {RW{1'b0}});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b001 || req_ready !== calc_gnt()) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected 001", req_ready);
    end
    tick();
    next_exp();
    checks++;
    if (rsp_obs !== cur) begin
      errors++;
      $display("FAIL reset_first_rsp: got %h expected %h", rsp_obs, cur);
    end
  endtask

  task automatic test_carry();
    req_valid = 3'b010;
    rsp_ready = 1'b1;
    set_req(1, 32'hFFFF_FFFF, 32'h0000_0001);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL carry_grant: got %b expected 010", req_ready);
    end
    tick();
    next_exp();
    checks++;
    if (rsp_obs !== {1'b1, 2'd1, 1'b1, 32'h0000_0000} || rsp_obs !== cur) begin
      errors++;
      $display("FAIL carry_rsp: got %h expected %h", rsp_obs, {1'b1, 2'd1, 1'b1, 32'h0});
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g[4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i), WIDTH'(10));
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_g[c] || req_ready !== calc_gnt()) begin
        errors++;
        $display("FAIL rr_grant cyc%0d: got %b expected %b", c, req_ready, exp_g[c]);
      end
      tick();
      next_exp();
      checks++;
      if (rsp_obs !== cur) begin
        errors++;
        $display("FAIL rr_rsp cyc%0d: got %h expected %h", c, rsp_obs, cur);
      end
    end
  endtask

  task automatic test_backpressure();
    req_valid = '1;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 3'b000) begin
        errors++;
        $display("FAIL bp_ready cyc%0d: got %b expected 000", c, req_ready);
      end
      tick();
      checks++;
      if (rsp_obs !== cur) begin
        errors++;
        $display("FAIL bp_frozen cyc%0d: got %h expected %h", c, rsp_obs, cur);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 3'b010 || req_ready !== calc_gnt()) begin
      errors++;
      $display("FAIL bp_release_grant: got %b expected 010", req_ready);
    end
    tick();
    next_exp();
    checks++;
    if (rsp_obs !== cur) begin
      errors++;
      $display("FAIL bp_release_rsp: got %h expected %h", rsp_obs, cur);
    end
  endtask

  task automatic test_pointer_skip();
    logic [NREQ-1:0] pat[3];
    logic [NREQ-1:0] exp_g[3];
    pat   = '{3'b111, 3'b101, 3'b101};
    exp_g = '{3'b100, 3'b001, 3'b100};
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_valid = pat[c];
      #1;
      checks++;
      if (req_ready !== exp_g[c] || req_ready !== calc_gnt()) begin
        errors++;
        $display("FAIL skip_grant cyc%0d: got %b expected %b", c, req_ready, exp_g[c]);
      end
      tick();
      next_exp();
      checks++;
      if (rsp_obs !== cur) begin
        errors++;
        $display("FAIL skip_rsp cyc%0d: got %h expected %h", c, rsp_obs, cur);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_valid = '1;
    rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL midrst_ready: got %b expected 000", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_valid: got %b expected 0", rsp_valid);
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 3'b001 || req_ready !== calc_gnt()) begin
      errors++;
      $display("FAIL midrst_grant: got %b expected 001", req_ready);
    end
    tick();
    next_exp();
    checks++;
    if (rsp_obs !== cur) begin
      errors++;
      $display("FAIL midrst_rsp: got %h expected %h", rsp_obs, cur);
    end
  endtask

  task automatic test_boundary();
    logic [WIDTH-1:0] ta[3];
    logic [WIDTH-1:0] tb[3];
    logic [WIDTH-1:0] ts[3];
    logic             tc[3];
    ta = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    tb = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    ts = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE};
    tc = '{1'b1, 1'b0, 1'b1};
    req_valid = 3'b001;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_req(0, ta[c], tb[c]);
      #1;
      checks++;
      if (req_ready !== calc_gnt()) begin
        errors++;
        $display("FAIL bnd_grant cyc%0d: got %b expected %b", c, req_ready, calc_gnt());
      end
      tick();
      next_exp();
      checks++;
      if ({rsp_cout, rsp_sum} !== {tc[c], ts[c]} || rsp_obs !== cur) begin
        errors++;
        $display("FAIL bnd_sum cyc%0d: got %b/%h expected %b/%h", c, rsp_cout, rsp_sum, tc[c], ts[c]);
      end
    end
    // Drain with no new request: valid drops, payload holds.
    req_valid = '0;
    #1;
    tick();
    checks++;
    if (rsp_obs !== {1'b0, cur[RW-2:0]}) begin
      errors++;
      $display("FAIL drain_idle: got %h expected %h", rsp_obs, {1'b0, cur[RW-2:0]});
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_reset_mid();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
